// File: rtl/draw_background_arena_if.sv
// Video stream bundle between the timing generator and the background renderer.
// master: upstream side driving counters/timing; slave: the renderer.
interface draw_background_arena_if;
  localparam int unsigned W = 12;

  logic [W-1:0] vcount_in;
  logic [W-1:0] hcount_in;
  logic         vsync_in;
  logic         vblnk_in;
  logic         hsync_in;
  logic         hblnk_in;

  logic [W-1:0] vcount_out;
  logic [W-1:0] hcount_out;
  logic         vsync_out;
  logic         vblnk_out;
  logic         hsync_out;
  logic         hblnk_out;
  logic [W-1:0] rgb_out;

  modport master (
    output vcount_in, hcount_in, vsync_in, vblnk_in, hsync_in, hblnk_in,
    input  vcount_out, hcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out, rgb_out
  );

  modport slave (
    input  vcount_in, hcount_in, vsync_in, vblnk_in, hsync_in, hblnk_in,
    output vcount_out, hcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out, rgb_out
  );
endinterface

// File: rtl/draw_background_arena.sv
// Per-mode background renderer with an animated game arena.
// Two-stage pipeline: stage 1 registers timing and region compares, stage 2 colour.
// Optional macro DRAW_BG_FADE_EN: fade-in from black after each mode change.
module draw_background_arena #(
  parameter int unsigned H_RES        = 1024,
  parameter int unsigned V_RES        = 768,
  parameter int unsigned ARENA_CX     = 511,
  parameter int unsigned ARENA_CY     = 467,
  parameter int unsigned DEF_HALF     = 150,
  parameter int unsigned MIN_HALF     = 40,
  parameter int unsigned MAX_HALF     = 300,
  parameter int unsigned STEP         = 1,
  parameter int unsigned BORDER       = 10,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  draw_background_arena_if.slave  vid,
  input  logic [2:0]              control_state,
  input  logic [11:0]             target_half_w,
  input  logic [11:0]             target_half_h,
  input  logic                    size_load,
  output logic [11:0]             arena_top,
  output logic [11:0]             arena_bottom,
  output logic [11:0]             arena_left,
  output logic [11:0]             arena_right,
  output logic                    anim_busy
);
  localparam int unsigned W   = 12;
  localparam int unsigned CW  = 4;
  localparam int unsigned BCW = $clog2(BLINK_FRAMES + 1);

  localparam logic [2:0] MODE_MENU      = 3'b000;
  localparam logic [2:0] MODE_GAME      = 3'b001;
  localparam logic [2:0] MODE_VICTORY   = 3'b010;
  localparam logic [2:0] MODE_GAME_OVER = 3'b011;
  localparam logic [2:0] MODE_MULTI     = 3'b100;

  logic [W-1:0]   half_w, half_h, target_w, target_h;
  logic [2:0]     mode_q;
  logic [BCW-1:0] blink_cnt;
  logic           blink_phase;
  logic [CW-1:0]  fade_level;
  logic           frame_start;

  logic [W-1:0] s1_vcount, s1_hcount;
  logic         s1_vsync, s1_vblnk, s1_hsync, s1_hblnk;
  logic         s1_top, s1_bot, s1_lft, s1_rgt, s1_border;

  logic [W-1:0] outer_l, outer_r, outer_t, outer_b;
  logic         in_outer, in_inner;
  logic [W-1:0] rgb_c, rgb_fade_c;

  function automatic logic [W-1:0] clamp_half(input logic [W-1:0] v);
    if (v < W'(MIN_HALF))      return W'(MIN_HALF);
    else if (v > W'(MAX_HALF)) return W'(MAX_HALF);
    else                       return v;
  endfunction

  function automatic logic [W-1:0] step_toward(input logic [W-1:0] cur, input logic [W-1:0] tgt);
    if (cur < tgt) return ((tgt - cur) > W'(STEP)) ? cur + W'(STEP) : tgt;
    else           return ((cur - tgt) > W'(STEP)) ? cur - W'(STEP) : tgt;
  endfunction

  function automatic logic [CW-1:0] sat_sub(input logic [CW-1:0] ch, input logic [CW-1:0] lvl);
    return (ch > lvl) ? ch - lvl : '0;
  endfunction

  // vsync_d is the stage-1 copy of vsync_in
  assign frame_start = vid.vsync_in & ~s1_vsync;

  // Border frame around the current arena bounds
  always_comb begin
    outer_l  = arena_left   - W'(BORDER);
    outer_r  = arena_right  + W'(BORDER);
    outer_t  = arena_top    - W'(BORDER);
    outer_b  = arena_bottom + W'(BORDER);
    in_outer = (vid.hcount_in >= outer_l) && (vid.hcount_in < outer_r) &&
               (vid.vcount_in >= outer_t) && (vid.vcount_in < outer_b);
    in_inner = (vid.hcount_in >= arena_left) && (vid.hcount_in < arena_right) &&
               (vid.vcount_in >= arena_top)  && (vid.vcount_in < arena_bottom);
  end

  // Stage 1: timing, counters and region compares
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vcount <= '0;
      s1_hcount <= '0;
      s1_vsync  <= 1'b0;
      s1_vblnk  <= 1'b0;
      s1_hsync  <= 1'b0;
      s1_hblnk  <= 1'b0;
      s1_top    <= 1'b0;
      s1_bot    <= 1'b0;
      s1_lft    <= 1'b0;
      s1_rgt    <= 1'b0;
      s1_border <= 1'b0;
    end else begin
      s1_vcount <= vid.vcount_in;
      s1_hcount <= vid.hcount_in;
      s1_vsync  <= vid.vsync_in;
      s1_vblnk  <= vid.vblnk_in;
      s1_hsync  <= vid.hsync_in;
      s1_hblnk  <= vid.hblnk_in;
      s1_top    <= (vid.vcount_in == '0);
      s1_bot    <= (vid.vcount_in == W'(V_RES - 1));
      s1_lft    <= (vid.hcount_in == '0);
      s1_rgt    <= (vid.hcount_in == W'(H_RES - 1));
      s1_border <= in_outer & ~in_inner;
    end
  end

  // Frame-rate state: targets, size animation, mode latch, blink, bounds
  always_ff @(posedge clk) begin
    if (!rst) begin
      target_w     <= W'(DEF_HALF);
      target_h     <= W'(DEF_HALF);
      half_w       <= W'(DEF_HALF);
      half_h       <= W'(DEF_HALF);
      mode_q       <= MODE_MENU;
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
      arena_left   <= W'(ARENA_CX - DEF_HALF);
      arena_right  <= W'(ARENA_CX + DEF_HALF);
      arena_top    <= W'(ARENA_CY - DEF_HALF);
      arena_bottom <= W'(ARENA_CY + DEF_HALF);
      anim_busy    <= 1'b0;
    end else begin
      if (size_load) begin
        target_w <= clamp_half(target_half_w);
        target_h <= clamp_half(target_half_h);
      end
      if (frame_start) begin
        mode_q <= control_state;
        half_w <= step_toward(half_w, target_w);
        half_h <= step_toward(half_h, target_h);
        if (blink_cnt == BCW'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BCW'(1);
        end
      end
      arena_left   <= W'(ARENA_CX) - half_w;
      arena_right  <= W'(ARENA_CX) + half_w;
      arena_top    <= W'(ARENA_CY) - half_h;
      arena_bottom <= W'(ARENA_CY) + half_h;
      anim_busy    <= (half_w != target_w) | (half_h != target_h);
    end
  end

`ifdef DRAW_BG_FADE_EN
  // Fade level reloads on a mode change and decays once per frame
  always_ff @(posedge clk) begin
    if (!rst) begin
      fade_level <= '0;
    end else if (frame_start) begin
      if (control_state != mode_q) fade_level <= CW'(15);
      else if (fade_level != '0)   fade_level <= fade_level - CW'(1);
    end
  end
`else
  assign fade_level = '0;
`endif

  // Pixel colour by priority: blanking, edge lines, arena border, mode fill
  always_comb begin
    rgb_c = '0;
    if (!(s1_vblnk | s1_hblnk)) begin
      case (mode_q)
        MODE_MENU, MODE_GAME: begin
          if (s1_top)                              rgb_c = 12'hFF0;
          else if (s1_bot)                         rgb_c = 12'hF00;
          else if (s1_lft)                         rgb_c = 12'h0F0;
          else if (s1_rgt)                         rgb_c = 12'h00F;
          else if ((mode_q == MODE_GAME) && s1_border) rgb_c = 12'hFFF;
          else                                     rgb_c = 12'h000;
        end
        MODE_VICTORY:   rgb_c = 12'h2F2;
        MODE_GAME_OVER: rgb_c = blink_phase ? 12'h811 : 12'hF22;
        MODE_MULTI:     rgb_c = 12'h22F;
        default:        rgb_c = 12'h000;
      endcase
    end
    rgb_fade_c = {sat_sub(rgb_c[11:8], fade_level),
                  sat_sub(rgb_c[7:4],  fade_level),
                  sat_sub(rgb_c[3:0],  fade_level)};
  end

  // Stage 2: delayed timing and colour outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      vid.vcount_out <= '0;
      vid.hcount_out <= '0;
      vid.vsync_out  <= 1'b0;
      vid.vblnk_out  <= 1'b0;
      vid.hsync_out  <= 1'b0;
      vid.hblnk_out  <= 1'b0;
      vid.rgb_out    <= '0;
    end else begin
      vid.vcount_out <= s1_vcount;
      vid.hcount_out <= s1_hcount;
      vid.vsync_out  <= s1_vsync;
      vid.vblnk_out  <= s1_vblnk;
      vid.hsync_out  <= s1_hsync;
      vid.hblnk_out  <= s1_hblnk;
      vid.rgb_out    <= rgb_fade_c;
    end
  end
endmodule

// File: tb/tb_draw_background_arena.sv
// Scoreboard bench for draw_background_arena: stimulus pushes expectations
// tagged with the cycle they are due, a negedge monitor compares them.
module tb_draw_background_arena;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ctrl;
  logic [11:0] target_half_w, target_half_h;
  logic        size_load;
  logic [11:0] arena_top, arena_bottom, arena_left, arena_right;
  logic        anim_busy;

  draw_background_arena_if bus();

  draw_background_arena dut (
    .clk           (clk),
    .rst           (rst),
    .vid           (bus),
    .control_state (ctrl),
    .target_half_w (target_half_w),
    .target_half_h (target_half_h),
    .size_load     (size_load),
    .arena_top     (arena_top),
    .arena_bottom  (arena_bottom),
    .arena_left    (arena_left),
    .arena_right   (arena_right),
    .anim_busy     (anim_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          sel;
    logic [11:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  int       fc = 0;        // frame_starts issued since reset
  int       fade_exp = 0;  // expected fade level
  logic [2:0] bmode = 3'd0;

  function automatic logic [11:0] actual(input int sel);
    case (sel)
      0: return bus.rgb_out;
      1: return bus.hcount_out;
      2: return bus.vcount_out;
      3: return 12'({bus.vsync_out, bus.vblnk_out, bus.hsync_out, bus.hblnk_out});
      4: return arena_left;
      5: return arena_right;
      6: return arena_top;
      7: return arena_bottom;
      8: return 12'(anim_busy);
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] fsat(input logic [11:0] c, input int lvl);
    logic [11:0] r;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      int ch;
      ch = int'(c[k*4 +: 4]) - lvl;
      r[k*4 +: 4] = (ch < 0) ? 4'd0 : 4'(ch);
    end
    return r;
  endfunction

  // Monitor: compare every expectation due this cycle
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        logic [11:0] a;
        a = actual(sb[i].sel);
        checks++;
        if (sb[i].due < cyc || a !== sb[i].exp) begin
          errors++;
          $display("FAIL %s: got %03h expected %03h (cycle %0d)", sb[i].name, a, sb[i].exp, cyc);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int lat, input int sel, input logic [11:0] exp, input string nm);
    exp_t e;
    e.due = cyc + lat; e.sel = sel; e.exp = exp; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [11:0] h, input logic [11:0] v,
                       input logic vs, input logic vb, input logic hs, input logic hb,
                       input bit chk, input logic [11:0] exp_rgb, input string nm);
    bus.hcount_in = h; bus.vcount_in = v;
    bus.vsync_in = vs; bus.vblnk_in = vb; bus.hsync_in = hs; bus.hblnk_in = hb;
    push(2, 1, h, {nm, "_hcount"});
    push(2, 2, v, {nm, "_vcount"});
    push(2, 3, 12'({vs, vb, hs, hb}), {nm, "_timing"});
    if (chk) push(2, 0, fsat(exp_rgb, fade_exp), {nm, "_rgb"});
    tick();
  endtask

  task automatic px(input logic [11:0] h, input logic [11:0] v, input logic [11:0] exp_rgb, input string nm);
    drive(h, v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_rgb, nm);
  endtask

  task automatic new_frame(input bit sl, input logic [11:0] tw, input logic [11:0] th);
    size_load = sl; target_half_w = tw; target_half_h = th;
    drive(12'd0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000, "vsync_cycle");
    size_load = 1'b0;
`ifdef DRAW_BG_FADE_EN
    if (ctrl != bmode) fade_exp = 15;
    else if (fade_exp > 0) fade_exp--;
`endif
    bmode = ctrl;
    fc++;
    drive(12'd0, 12'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000, "vblank_cycle");
  endtask

  task automatic load(input logic [11:0] tw, input logic [11:0] th);
    size_load = 1'b1; target_half_w = tw; target_half_h = th;
    drive(12'd0, 12'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, "load");
    size_load = 1'b0;
    drive(12'd0, 12'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, "load_idle");
  endtask

  task automatic chk_bounds(input logic [11:0] l, input logic [11:0] r, input logic [11:0] t,
                            input logic [11:0] b, input logic busy, input string nm);
    push(0, 4, l, {nm, "_left"});
    push(0, 5, r, {nm, "_right"});
    push(0, 6, t, {nm, "_top"});
    push(0, 7, b, {nm, "_bottom"});
    push(0, 8, 12'(busy), {nm, "_busy"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ctrl = 3'd0; size_load = 1'b0;
    target_half_w = 12'd0; target_half_h = 12'd0;
    bus.hcount_in = 12'd5; bus.vcount_in = 12'd7;
    bus.vsync_in = 1'b0; bus.vblnk_in = 1'b0; bus.hsync_in = 1'b1; bus.hblnk_in = 1'b0;

    // Reset: outputs cleared, bounds at defaults
    tick(); tick();
    push(0, 0, 12'h000, "rst_rgb");
    push(0, 1, 12'h000, "rst_hcount");
    push(0, 3, 12'h000, "rst_timing");
    chk_bounds(12'd361, 12'd661, 12'd317, 12'd617, 1'b0, "rst");
    tick(); tick();
    bus.hcount_in = 12'd0; bus.vcount_in = 12'd0; bus.hsync_in = 1'b0;
    rst = 1'b1;
    tick();

    // Test 1: GAME border/interior/edges at default bounds
    ctrl = 3'd1;
    new_frame(1'b0, 12'd0, 12'd0);
    chk_bounds(12'd361, 12'd661, 12'd317, 12'd617, 1'b0, "t1");
    px(12'd361,  12'd317, 12'h000, "t1_interior_corner");
    px(12'd355,  12'd400, 12'hFFF, "t1_left_border");
    px(12'd350,  12'd400, 12'h000, "t1_outside_left");
    px(12'd661,  12'd400, 12'hFFF, "t1_right_border_first");
    px(12'd670,  12'd400, 12'hFFF, "t1_right_border_last");
    px(12'd671,  12'd400, 12'h000, "t1_outside_right");
    px(12'd400,  12'd307, 12'hFFF, "t1_top_border_first");
    px(12'd400,  12'd306, 12'h000, "t1_outside_top");
    px(12'd660,  12'd616, 12'h000, "t1_interior_far");
    px(12'd5,    12'd0,   12'hFF0, "t1_top_edge");
    px(12'd5,    12'd767, 12'hF00, "t1_bottom_edge");
    px(12'd0,    12'd100, 12'h0F0, "t1_left_edge");
    px(12'd1023, 12'd100, 12'h00F, "t1_right_edge");
    drive(12'd355, 12'd400, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, "t1_blanked_border");

    // Test 2: grow half_w to 160
    load(12'd160, 12'd150);
    chk_bounds(12'd361, 12'd661, 12'd317, 12'd617, 1'b1, "t2_loaded");
    for (int f = 1; f <= 10; f++) begin
      new_frame(1'b0, 12'd0, 12'd0);
      if (f == 5) chk_bounds(12'd356, 12'd666, 12'd317, 12'd617, 1'b1, "t2_mid");
    end
    chk_bounds(12'd351, 12'd671, 12'd317, 12'd617, 1'b0, "t2_done");
    px(12'd341, 12'd400, 12'hFFF, "t2_new_border");
    px(12'd340, 12'd400, 12'h000, "t2_new_outside");
    new_frame(1'b0, 12'd0, 12'd0);
    chk_bounds(12'd351, 12'd671, 12'd317, 12'd617, 1'b0, "t2_hold");

    // Test 3: clamp to MIN then MAX, 1 px per frame
    load(12'd5, 12'd5);
    new_frame(1'b0, 12'd0, 12'd0);
    chk_bounds(12'd352, 12'd670, 12'd318, 12'd616, 1'b1, "t3_min_step1");
    for (int f = 0; f < 119; f++) new_frame(1'b0, 12'd0, 12'd0);
    chk_bounds(12'd471, 12'd551, 12'd427, 12'd507, 1'b0, "t3_min_done");
    load(12'd1000, 12'd1000);
    new_frame(1'b0, 12'd0, 12'd0);
    chk_bounds(12'd470, 12'd552, 12'd426, 12'd508, 1'b1, "t3_max_step1");
    for (int f = 0; f < 259; f++) new_frame(1'b0, 12'd0, 12'd0);
    chk_bounds(12'd211, 12'd811, 12'd167, 12'd767, 1'b0, "t3_max_done");

    // size_load coinciding with frame_start: step uses the old target
    new_frame(1'b1, 12'd200, 12'd300);
    chk_bounds(12'd211, 12'd811, 12'd167, 12'd767, 1'b1, "same_cycle_load");
    new_frame(1'b0, 12'd0, 12'd0);
    chk_bounds(12'd212, 12'd810, 12'd167, 12'd767, 1'b1, "same_cycle_next");

    // Test 4: mode change mid-frame waits for frame_start
    ctrl = 3'd0;
    new_frame(1'b0, 12'd0, 12'd0);
    px(12'd511, 12'd160, 12'h000, "t4_menu_border_pos");
    ctrl = 3'd1;
    px(12'd511, 12'd160, 12'h000, "t4_midframe_still_menu");
    px(12'd0,   12'd300, 12'h0F0, "t4_midframe_edge");
    new_frame(1'b0, 12'd0, 12'd0);
    px(12'd511, 12'd160, 12'hFFF, "t4_game_border");

    // Test 5: GAME_OVER blink over 60 frames
    ctrl = 3'd3;
    for (int f = 0; f < 60; f++) begin
      new_frame(1'b0, 12'd0, 12'd0);
      px(12'd511, 12'd400, (((fc / 30) % 2) == 1) ? 12'h811 : 12'hF22, "t5_gameover_fill");
    end
    drive(12'd511, 12'd400, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000, "t5_vblank_black");

    // Remaining fills
    ctrl = 3'd2;
    new_frame(1'b0, 12'd0, 12'd0);
    px(12'd511, 12'd400, 12'h2F2, "victory_fill");
    px(12'd0,   12'd400, 12'h2F2, "victory_solid_at_edge");
    ctrl = 3'd4;
    new_frame(1'b0, 12'd0, 12'd0);
    px(12'd511, 12'd400, 12'h22F, "multi_wait_fill");
    ctrl = 3'd7;
    new_frame(1'b0, 12'd0, 12'd0);
    px(12'd511, 12'd400, 12'h000, "undefined_fill");
    px(12'd0,   12'd0,   12'h000, "undefined_edge");

`ifdef DRAW_BG_FADE_EN
    // Test 6: fade-in after switching to VICTORY
    ctrl = 3'd2;
    new_frame(1'b0, 12'd0, 12'd0);
    push(2, 0, 12'h000, "t6_fade_first");
    drive(12'd511, 12'd400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, "t6_first");
    for (int f = 1; f <= 15; f++) begin
      new_frame(1'b0, 12'd0, 12'd0);
      if (f == 14) push(2, 0, 12'h1E1, "t6_fade_frame14");
      if (f == 15) push(2, 0, 12'h2F2, "t6_fade_frame15");
      drive(12'd511, 12'd400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, "t6_frame");
    end
`endif

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      errors += sb.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/draw_background_arena.md
Name: draw_background_arena

Overview:
Parametrised successor of the background renderer. Generates the per-mode background for the VGA pipeline, with a game arena whose size animates frame by frame toward a requested target. Arena bounds are published for collision and object-draw blocks. Sits directly after the timing generator; all timing signals pass through with a fixed latency.

Parameters:
H_RES, 1024, active pixels per line; right edge line is drawn at H_RES-1.
V_RES, 768, active lines; bottom edge line is drawn at V_RES-1.
ARENA_CX, 511, arena centre column.
ARENA_CY, 467, arena centre row.
DEF_HALF, 150, reset half-width and half-height of the arena.
MIN_HALF, 40, lower clamp for the target half size.
MAX_HALF, 300, upper clamp for the target half size.
STEP, 1, maximum half-size change per frame, in pixels.
BORDER, 10, arena border thickness in pixels.
BLINK_FRAMES, 30, frames per blink phase in GAME_OVER.

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-low
vcount_in, hcount_in  in  12  pixel counters
vsync_in, vblnk_in, hsync_in, hblnk_in  in  1  timing signals
control_state  in  3  modes: 000 MENU, 001 GAME, 010 VICTORY, 011 GAME_OVER, 100 MULTI_WAIT
target_half_w, target_half_h  in  12  requested arena half size
size_load  in  1  single-cycle strobe that captures the targets
vcount_out, hcount_out  out  12  delayed counters
vsync_out, vblnk_out, hsync_out, hblnk_out  out  1  delayed timing signals
rgb_out  out  12  pixel colour
arena_top, arena_bottom, arena_left, arena_right  out  12  current inner bounds
anim_busy  out  1  high while the current size differs from the target

Behaviour:
- Reset (rst==0 at a clk edge):
  - All timing and rgb outputs are 0; anim_busy is 0.
  - half_w, half_h and both targets are DEF_HALF; the latched mode is MENU.
  - Blink counter and blink phase are 0; fade level is 0.
  - Bounds take their default values (361/661/317/617 with default parameters).
- Latency: every *_out signal and rgb_out is exactly 2 clk cycles behind its input. Stage 1 registers timing, counters and region compares. Stage 2 registers colour.
- frame_start = vsync_in & ~vsync_d, where vsync_d is a registered copy of vsync_in.
- size_load: target_* <= clamp(input, MIN_HALF, MAX_HALF), effective the next cycle.
- On frame_start:
  - mode_q <= control_state. The mode is latched only at frame start, so a mode change never tears a frame.
  - half_x moves toward target_x by min(STEP, |diff|); no overshoot.
  - The blink counter increments; when it reaches BLINK_FRAMES-1 it wraps to 0 and toggles the blink phase.
- If size_load and frame_start occur in the same cycle, the step uses the old target; the new target is captured as usual.
- Bounds:
  - left = ARENA_CX - half_w; right = ARENA_CX + half_w; top = ARENA_CY - half_h; bottom = ARENA_CY + half_h.
  - Bounds are registered and change only in the cycle after frame_start.
- anim_busy = (half_w != target_w) | (half_h != target_h), registered.
- Pixel priority, highest first:
  - blanking → 000;
  - vcount==0 → FF0; vcount==V_RES-1 → F00; hcount==0 → 0F0; hcount==H_RES-1 → 00F;
  - arena border (GAME only) → FFF;
  - mode fill.
- Arena border region: the frame of width BORDER surrounding [left,right) x [top,bottom), i.e. h in [left-BORDER, right+BORDER) and v in [top-BORDER, bottom+BORDER), excluding the interior.
- Mode fills:
  - MENU: 000 fill, edge lines drawn.
  - GAME: 000 fill, edge lines and border drawn.
  - VICTORY: solid 2F2.
  - GAME_OVER: solid F22 in phase 0, 811 in phase 1.
  - MULTI_WAIT: solid 22F.
  - Undefined codes: 000.
  - VICTORY, GAME_OVER and MULTI_WAIT ignore blanking priority only for edge lines; blanking is still black.
- Counters are unsigned 12-bit. The clamp guarantees CX ± half stays in range with the default parameters; no wrap-around handling is required beyond that.

Optional Feature:
- Macro: DRAW_BG_FADE_EN.
- Defined:
  - When mode_q changes at a frame_start, fade_level is set to 15.
  - fade_level decrements by 1 on each subsequent frame_start down to 0.
  - Stage 2 outputs each 4-bit channel as saturating (ch - fade_level), floored at 0.
  - A new mode change during a fade reloads the level to 15.
- Not defined: fade_level is a constant 0 and colours switch immediately.

Test Plan:
1. Reset low for 4 clk, release; drive a pixel at h=361, v=317 in GAME with the mode latched → rgb_out 000 two cycles later; pixel at h=355, v=400 → FFF; arena_left=361, arena_right=661.
2. Pulse size_load with target_half_w=160, target_half_h=150 → anim_busy=1; after 10 frame_starts arena_left=351, arena_right=671, anim_busy=0; the 11th frame leaves the bounds unchanged.
3. size_load with target_half_w=5, then 1000 → targets clamp to 40 and 300; the bounds converge to 471/551, then to 211/811, at 1 px/frame.
4. Change control_state from MENU to GAME mid-frame → rgb for the rest of that frame follows MENU; the switch takes effect from the next frame_start.
5. GAME_OVER held for 60 frames → fill F22 for frames 0-29 and 811 for frames 30-59; timing outputs equal the inputs delayed by exactly 2 cycles.
6. With DRAW_BG_FADE_EN defined, switch to VICTORY → first frame rgb 000 (2F2 minus 15, saturated); frame 14 2F2 minus 1 = 1E1; frame 15 onward 2F2.
